// File: rtl/ahb_matrix_pkg.sv
// rtl/ahb_matrix_pkg.sv - shared types and defaults for the AHB slave-port arbiter
package ahb_matrix_pkg;

  localparam int MASTERS_DEFAULT = 4;

  // L-states keep the bus locked to lock_owner between and during transfers
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_LIDLE = 2'd2,
    ST_LDATA = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// rtl/ahb_slave_arbiter_if.sv - request/ack and slave-side handshake bundle for one slave port
interface ahb_slave_arbiter_if
  import ahb_matrix_pkg::*;
#(
  parameter int MASTERS = MASTERS_DEFAULT
);

  logic [MASTERS-1:0] m_addr_req;
  logic [MASTERS-1:0] m_hmastlock;
  logic [MASTERS-1:0] m_addr_ack;
  logic [MASTERS-1:0] m_data_ack;
  logic [MASTERS-1:0] s_addr_sel;
  logic [MASTERS-1:0] s_data_sel;
  logic               S_HSEL;
  logic               S_HREADY;
  logic               S_HREADYOUT;

  // master side: the requesting masters plus the slave's ready
  modport master (
    output m_addr_req, m_hmastlock, S_HREADYOUT,
    input  m_addr_ack, m_data_ack, s_addr_sel, s_data_sel, S_HSEL, S_HREADY
  );

  // slave side: the arbiter itself
  modport slave (
    input  m_addr_req, m_hmastlock, S_HREADYOUT,
    output m_addr_ack, m_data_ack, s_addr_sel, s_data_sel, S_HSEL, S_HREADY
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - round-robin search starting one past the last winner
module ahb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          win_valid
);

  int idx;

  // walk last+1 .. last+N so the previous winner is considered last
  always_comb begin
    win       = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!win_valid && req[IW'(idx)]) begin
        win_valid          = 1'b1;
        win[IW'(idx)]      = 1'b1;
        win_idx            = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// rtl/ahb_slave_arbiter.sv - round-robin arbiter with lock support in front of one AHB slave
module ahb_slave_arbiter
  import ahb_matrix_pkg::*;
#(
  parameter int MASTERS = MASTERS_DEFAULT
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_slave_arbiter_if.slave bus
);

  localparam int IW = $clog2(MASTERS);
  localparam logic [MASTERS-1:0] ONE = MASTERS'(1);

  arb_state_e         state, state_nxt;
  logic [IW-1:0]      last_grant, owner, lock_owner;
  logic               in_data, locked, hready, grant, win_lock;
  logic [MASTERS-1:0] eligible, win, owner_mask;
  logic [IW-1:0]      win_idx;
  logic               win_valid;

  assign in_data    = (state == ST_DATA) || (state == ST_LDATA);
  assign locked     = (state == ST_LIDLE) || (state == ST_LDATA);
  assign hready     = in_data ? bus.S_HREADYOUT : 1'b1;
  assign owner_mask = ONE << owner;
  // while locked only the lock owner may win; everyone else is held off
  assign eligible   = locked ? (bus.m_addr_req & (ONE << lock_owner)) : bus.m_addr_req;

  ahb_rr_picker #(.N(MASTERS), .IW(IW)) u_picker (
    .req       (eligible),
    .last      (last_grant),
    .win       (win),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign grant    = win_valid && hready;
  assign win_lock = bus.m_hmastlock[win_idx];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      last_grant <= IW'(MASTERS - 1);
      owner      <= '0;
      lock_owner <= '0;
    end else if (grant) begin
      last_grant <= win_idx;
      owner      <= win_idx;
      if (win_lock) begin
        lock_owner <= win_idx;
      end
    end
  end

  // a new grant overrides completion so back-to-back transfers pipeline
  always_comb begin
    state_nxt = state;
    if (grant) begin
      state_nxt = win_lock ? ST_LDATA : ST_DATA;
    end else if (in_data && bus.S_HREADYOUT) begin
      state_nxt = locked ? ST_LIDLE : ST_IDLE;
    end
  end

  always_comb begin
    bus.m_addr_ack = '0;
    bus.s_addr_sel = '0;
    bus.S_HSEL     = 1'b0;
    bus.s_data_sel = '0;
    bus.m_data_ack = '0;
    bus.S_HREADY   = hready;
    if (grant) begin
      bus.m_addr_ack = win;
      bus.s_addr_sel = win;
      bus.S_HSEL     = 1'b1;
    end
    if (in_data) begin
      bus.s_data_sel = owner_mask;
      if (bus.S_HREADYOUT) begin
        bus.m_data_ack = owner_mask;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb/tb_ahb_slave_arbiter.sv - directed vectors with a queued scoreboard for ahb_slave_arbiter
module tb_ahb_slave_arbiter;

  typedef struct packed {
    logic [3:0] aack;
    logic [3:0] dack;
    logic [3:0] dsel;
    logic       hsel;
    logic       hready;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  ahb_slave_arbiter_if #(.MASTERS(4)) bus ();

  ahb_slave_arbiter #(.MASTERS(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic vec(input logic [3:0] req, input logic [3:0] lock, input logic hro,
                     input logic rstn, input logic [3:0] aack, input logic [3:0] dack,
                     input logic [3:0] dsel, input logic hsel, input logic hready);
    exp_t e;
    @(posedge HCLK);
    #1;
    bus.m_addr_req  = req;
    bus.m_hmastlock = lock;
    bus.S_HREADYOUT = hro;
    HRESETn         = rstn;
    e.aack   = aack;
    e.dack   = dack;
    e.dsel   = dsel;
    e.hsel   = hsel;
    e.hready = hready;
    exp_q.push_back(e);
  endtask

  // monitor: every cycle with a pending expectation, compare everything the DUT shows
  initial begin
    exp_t e, act;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bus.m_addr_ack, bus.m_data_ack, bus.s_data_sel, bus.S_HSEL, bus.S_HREADY};
        vectors++;
        if (act !== e || bus.s_addr_sel !== e.aack) begin
          miscompares++;
          $display("FAIL vec%0d: aack=%b dack=%b dsel=%b asel=%b hsel=%b hready=%b required aack=%b dack=%b dsel=%b asel=%b hsel=%b hready=%b",
                   vectors, act.aack, act.dack, act.dsel, bus.s_addr_sel, act.hsel, act.hready,
                   e.aack, e.dack, e.dsel, e.aack, e.hsel, e.hready);
        end
      end
    end
  end

  initial begin
    HRESETn         = 1'b0;
    bus.m_addr_req  = '0;
    bus.m_hmastlock = '0;
    bus.S_HREADYOUT = 1'b1;
    repeat (2) @(posedge HCLK);

    //   req      lock     hro  rst   aack     dack     dsel     hsel  hready
    vec(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    // four-way round robin with zero-wait slave
    vec(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0001, 4'b0001, 1'b1, 1'b1);
    vec(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0010, 4'b0010, 1'b1, 1'b1);
    vec(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0100, 4'b0100, 1'b1, 1'b1);
    vec(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b1000, 4'b1000, 1'b1, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    // master 2 with three wait states; competing requests withdrawn before any grant
    vec(4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b1011, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
    vec(4'b1011, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
    vec(4'b1011, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    // locked sequence by master 1, then master 3 wins after unlock
    vec(4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b1011, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1);
    vec(4'b1001, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b1);
    vec(4'b1001, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    vec(4'b1011, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b1001, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0010, 4'b0010, 1'b1, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1);
    // last_grant=3 and only master 3 requesting: it wins again
    vec(4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1);
    // reset during master 2 data phase abandons it; priority restarts at master 0
    vec(4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    vec(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b1);
    vec(4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);

    repeat (3) @(posedge HCLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
